alu_exec_unit: RTL and testbench

//   Responder side of the push-button operand/opcode interface. Samples A, B and
//   OP when start_op pulses and executes the operation: single-cycle logic and

---
 rtl/alu_exec_unit.sv | 167 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Operand/opcode responder: single-cycle logic/arithmetic ops, iterative shift-add
// multiply and optional restoring divide (enabled by defining ALU_DIV_EN).
module alu_exec_unit #(
  parameter int W = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_op,
  input  logic           leds_clear,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  input  logic [2:0]     op_in,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] leds,
  output logic           err_led
);

  // state | meaning
  // IDLE  | waiting for start_op
  // EXEC  | single-cycle op (or error) completes on the next edge
  // MUL   | shift-add multiply, W iterations
  // DIV   | restoring divide, W iterations (ALU_DIV_EN builds only)
  typedef enum logic [1:0] {IDLE, EXEC, MUL, DIV} state_t;

  localparam int CNT_W = $clog2(W + 1);

  state_t           state, state_next;
  logic [W-1:0]     a_r, b_r;
  logic [2:0]       op_r;
  logic [2*W-1:0]   acc, mcand;
  logic [W-1:0]     mplier;
  logic [CNT_W-1:0] cnt;

  logic             last_iter;
  logic [2*W-1:0]   a_ext, b_ext, exec_result, mul_acc_next;
  logic             exec_err;
  logic             div_start;

  assign last_iter = (cnt == CNT_W'(1));
  assign busy      = (state != IDLE);
  assign a_ext     = {{W{1'b0}}, a_r};
  assign b_ext     = {{W{1'b0}}, b_r};
  // Op 7 only reaches EXEC as an error: divider absent, or divide by zero.
  assign exec_err  = (op_r == 3'd7);

`ifdef ALU_DIV_EN
  assign div_start = (op_in == 3'd7) && (b_in != '0);
`else
  assign div_start = 1'b0;
`endif

  always_comb begin
    exec_result = '0;
    case (op_r)
      3'd0: exec_result = a_ext + b_ext;
      3'd1: exec_result = a_ext - b_ext;
      3'd2: exec_result = a_ext & b_ext;
      3'd3: exec_result = a_ext | b_ext;
      3'd4: exec_result = a_ext ^ b_ext;
      3'd5: exec_result = {{W{1'b0}}, ~a_r};
      default: exec_result = '0;
    endcase
  end

  assign mul_acc_next = acc + (mplier[0] ? mcand : '0);

`ifdef ALU_DIV_EN
  // Remainder lives in acc[W-1:0]; mplier holds the dividend shifting into the quotient.
  logic [W:0]   rem_sh;
  logic [W-1:0] rem_next, quot_next;

  always_comb begin
    rem_sh    = {acc[W-1:0], mplier[W-1]};
    quot_next = {mplier[W-2:0], 1'b0};
    rem_next  = rem_sh[W-1:0];
    if (rem_sh >= {1'b0, b_r}) begin
      rem_next     = W'(rem_sh - {1'b0, b_r});
      quot_next[0] = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_op) begin
        if (op_in == 3'd6)  state_next = MUL;
        else if (div_start) state_next = DIV;
        else                state_next = EXEC;
      end
      EXEC:    state_next = IDLE;
      MUL:     if (last_iter) state_next = IDLE;
      DIV:     if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (leds_clear) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      leds    <= '0;
      err_led <= 1'b0;
    end else begin
      done <= 1'b0;
      if (leds_clear) begin
        leds    <= '0;
        err_led <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start_op) begin
            a_r    <= a_in;
            b_r    <= b_in;
            op_r   <= op_in;
            acc    <= '0;
            mcand  <= {{W{1'b0}}, a_in};
            mplier <= div_start ? a_in : b_in;
            cnt    <= CNT_W'(W);
          end
          EXEC: begin
            leds    <= exec_err ? '0 : exec_result;
            err_led <= exec_err;
            done    <= 1'b1;
          end
          MUL: begin
            acc    <= mul_acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
            if (last_iter) begin
              leds    <= mul_acc_next;
              err_led <= 1'b0;
              done    <= 1'b1;
            end
          end
`ifdef ALU_DIV_EN
          DIV: begin
            acc    <= {{W{1'b0}}, rem_next};
            mplier <= quot_next;
            cnt    <= cnt - CNT_W'(1);
            if (last_iter) begin
              leds    <= {rem_next, quot_next};
              err_led <= 1'b0;
              done    <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed plus randomized checks of alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           start_op;
  logic           leds_clear;
  logic [W-1:0]   a_in, b_in;
  logic [2:0]     op_in;
  logic           busy, done, err_led;
  logic [2*W-1:0] leds;

  int vectors = 0;
  int miscompares = 0;

  alu_exec_unit #(.W(W)) dut (
    .clk(clk), .reset(reset), .start_op(start_op), .leds_clear(leds_clear),
    .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .busy(busy), .done(done), .leds(leds), .err_led(err_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns {err, leds} for an operation, from plain integer arithmetic.
  function automatic int model(input int a, input int b, input int op);
    int r;
    bit e;
    r = 0;
    e = 1'b0;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 7 - a;
      6: r = a * b;
      default: begin
`ifdef ALU_DIV_EN
        if (b == 0) e = 1'b1;
        else r = (a % b) * 8 + a / b;
`else
        e = 1'b1;
`endif
      end
    endcase
    if (e) r = 0;
    return (int'(e) << 6) | (r & 63);
  endfunction

  function automatic int latency(input int b, input int op);
    if (op == 6) return W;
`ifdef ALU_DIV_EN
    if (op == 7 && b != 0) return W;
`endif
    return 1;
  endfunction

  task automatic run_op(input int a, input int b, input int op);
    int exp, lat, n;
    exp = model(a, b, op);
    lat = latency(b, op);
    @(negedge clk);
    a_in = W'(a); b_in = W'(b); op_in = 3'(op); start_op = 1'b1;
    @(posedge clk); #1;
    start_op = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    n = 1;
    while (!done && n < 12) begin
      @(posedge clk); #1;
      if (!done) n++;
    end
    chk("done_latency", n, lat);
    chk("leds", int'(leds), exp & 63);
    chk("err_led", int'(err_led), exp >> 6);
    chk("busy_at_done", int'(busy), 0);
  endtask

  initial begin
    int a, b, op;
    reset = 1'b1; start_op = 1'b0; leds_clear = 1'b0;
    a_in = '0; b_in = '0; op_in = '0;
    #12;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_leds", int'(leds), 0);
    chk("reset_err", int'(err_led), 0);
    @(negedge clk); reset = 1'b0;

    // Directed single-cycle ops and the unsupported/zero-divisor path
    run_op(3, 5, 0);
    chk("add_3_5", int'(leds), 6'b001000);
    run_op(2, 5, 1);
    chk("sub_2_5", int'(leds), 6'b111101);
    run_op(5, 0, 5);
    chk("not_5", int'(leds), 6'b000010);
    run_op(7, 0, 7);
    chk("op7_b0_err", int'(err_led), 1);
    run_op(7, 2, 7);
    run_op(1, 1, 0);
    chk("err_cleared", int'(err_led), 0);

    // MUL 7*7 with a start_op during busy that must be ignored
    @(negedge clk);
    a_in = 3'd7; b_in = 3'd7; op_in = 3'd6; start_op = 1'b1;
    @(posedge clk); #1;
    chk("mul_busy_n", int'(busy), 1);
    @(negedge clk);
    a_in = 3'd1; b_in = 3'd1; op_in = 3'd0;
    @(posedge clk); #1;
    start_op = 1'b0;
    chk("mul_busy_n1", int'(busy), 1);
    chk("mul_nodone_n1", int'(done), 0);
    @(posedge clk); #1;
    chk("mul_busy_n2", int'(busy), 1);
    chk("mul_nodone_n2", int'(done), 0);
    @(posedge clk); #1;
    chk("mul_done_n3", int'(done), 1);
    chk("mul_49", int'(leds), 6'b110001);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
    chk("ignored_start_idle", int'(busy), 0);

    // start_op coinciding with a done pulse is dropped
    @(negedge clk);
    a_in = 3'd2; b_in = 3'd3; op_in = 3'd0; start_op = 1'b1;
    @(posedge clk); #1;
    op_in = 3'd4;
    @(posedge clk); #1;
    start_op = 1'b0;
    chk("done_edge_done", int'(done), 1);
    chk("done_edge_leds", int'(leds), 5);
    @(posedge clk); #1;
    chk("done_edge_start_dropped", int'(busy), 0);

    // Abort MUL 6*5 with leds_clear at N+2
    @(negedge clk);
    a_in = 3'd6; b_in = 3'd5; op_in = 3'd6; start_op = 1'b1;
    @(posedge clk); #1;
    start_op = 1'b0;
    @(posedge clk); #1;
    leds_clear = 1'b1;
    @(posedge clk); #1;
    leds_clear = 1'b0;
    chk("clr_busy", int'(busy), 0);
    chk("clr_leds", int'(leds), 0);
    chk("clr_err", int'(err_led), 0);
    for (int i = 0; i < 4; i++) begin
      chk("clr_no_done", int'(done), 0);
      @(posedge clk); #1;
    end
    run_op(1, 1, 0);
    chk("after_clr_add", int'(leds), 6'b000010);

    // Reset mid-MUL
    @(negedge clk);
    a_in = 3'd5; b_in = 3'd3; op_in = 3'd6; start_op = 1'b1;
    @(posedge clk); #1;
    start_op = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_leds", int'(leds), 0);
    chk("rst_mid_done", int'(done), 0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_mid_no_done", int'(done), 0);
    end

    // leds_clear and start_op in the same cycle: clear wins
    run_op(3, 3, 3);
    @(negedge clk);
    a_in = 3'd4; b_in = 3'd4; op_in = 3'd0; start_op = 1'b1; leds_clear = 1'b1;
    @(posedge clk); #1;
    start_op = 1'b0; leds_clear = 1'b0;
    chk("clr_start_busy", int'(busy), 0);
    chk("clr_start_leds", int'(leds), 0);
    @(posedge clk); #1;
    chk("clr_start_no_done", int'(done), 0);

    // Randomized back-to-back operations
    for (int i = 0; i < 60; i++) begin
      a  = int'($urandom_range(7, 0));
      b  = int'($urandom_range(7, 0));
      op = int'($urandom_range(7, 0));
      run_op(a, b, op);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
